// File: rtl/snake_food_gen.sv
// Food placement and eat detection for the 8x8 snake game.
// Probes one pseudo-random cell per clock for a free spot, arms food there,
// and pulses length_up / bumps the score when the head lands on it.
module snake_food_gen #(
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    parameter int unsigned MAX_SCORE = 60
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            move_tick,
    input  logic [7:0][7:0] head_position,
    input  logic [7:0][7:0] headplusbody,
    output logic [7:0][7:0] food_position,
    output logic            food_valid,
    output logic            length_up,
    output logic [7:0]      score,
    output logic            board_full,
    output logic            game_won
);

    localparam int unsigned CELLS     = 64;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned CNT_W     = 7;
    localparam int unsigned SCORE_W   = 8;
    localparam logic [7:0]  SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ARMED  = 2'd1,
        FULL   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          lfsr_q;
    logic [IDX_W-1:0]    probe_idx_q, probe_idx_d;
    logic [CNT_W-1:0]    probe_cnt_q, probe_cnt_d;
    logic [CELLS-1:0]    food_q, food_d;
    logic                food_valid_d, length_up_d, board_full_d, game_won_d;
    logic [SCORE_W-1:0]  score_d;
    logic [CELLS-1:0]    occ_c;
    logic [CELLS-1:0]    head_c;
    logic                lfsr_fb_c;
    logic                hit_c;
    logic [SCORE_W-1:0]  score_inc_c;

    assign occ_c       = headplusbody;
    assign head_c      = head_position;
    assign lfsr_fb_c   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign hit_c       = move_tick && ((head_c & food_q) != '0);
    assign score_inc_c = score + SCORE_W'(1);
    assign food_position = food_q;

    // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1; nonzero seed keeps it off zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_fb_c};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SEARCH;
            probe_idx_q <= SEED[IDX_W-1:0];
            probe_cnt_q <= '0;
            food_q      <= '0;
            food_valid  <= 1'b0;
            length_up   <= 1'b0;
            score       <= '0;
            board_full  <= 1'b0;
            game_won    <= 1'b0;
        end else begin
            state_q     <= state_d;
            probe_idx_q <= probe_idx_d;
            probe_cnt_q <= probe_cnt_d;
            food_q      <= food_d;
            food_valid  <= food_valid_d;
            length_up   <= length_up_d;
            score       <= score_d;
            board_full  <= board_full_d;
            game_won    <= game_won_d;
        end
    end

    // Next-state and next-output logic; length_up defaults low so it can only pulse.
    always_comb begin
        state_d      = state_q;
        probe_idx_d  = probe_idx_q;
        probe_cnt_d  = probe_cnt_q;
        food_d       = food_q;
        food_valid_d = food_valid;
        length_up_d  = 1'b0;
        score_d      = score;
        board_full_d = board_full;
        game_won_d   = game_won;

        case (state_q)
            SEARCH: begin
                if (!occ_c[probe_idx_q]) begin
                    food_d       = CELLS'(1) << probe_idx_q;
                    food_valid_d = 1'b1;
                    state_d      = ARMED;
                end else begin
                    probe_idx_d = probe_idx_q + IDX_W'(1);
                    probe_cnt_d = probe_cnt_q + CNT_W'(1);
                    // 64th consecutive occupied probe: nowhere left to put food.
                    if (probe_cnt_q == CNT_W'(CELLS - 1)) begin
                        board_full_d = 1'b1;
                        state_d      = FULL;
                    end
                end
            end
            ARMED: begin
                if (hit_c) begin
                    length_up_d  = 1'b1;
                    score_d      = score_inc_c;
                    food_d       = '0;
                    food_valid_d = 1'b0;
                    probe_idx_d  = lfsr_q[IDX_W-1:0];
                    probe_cnt_d  = '0;
                    if (score_inc_c == MAX_S) begin
                        game_won_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = SEARCH;
                    end
                end
            end
            FULL: begin
                food_d       = '0;
                food_valid_d = 1'b0;
                board_full_d = 1'b1;
            end
            DONE: begin
                food_d       = '0;
                food_valid_d = 1'b0;
                game_won_d   = 1'b1;
                score_d      = MAX_S;
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

endmodule

// File: tb/tb_snake_food_gen.sv
// Directed bench for snake_food_gen: placement, eating, wrap, full board, win, async reset.
module tb_snake_food_gen;

    logic            clk;
    logic            reset;
    logic            move_tick;
    logic [7:0][7:0] head_position;
    logic [7:0][7:0] headplusbody;

    logic [7:0][7:0] food_position, food_position2;
    logic            food_valid, food_valid2;
    logic            length_up, length_up2;
    logic [7:0]      score, score2;
    logic            board_full, board_full2;
    logic            game_won, game_won2;

    int tests_run;
    int tests_failed;
    int n;

    snake_food_gen dut (
        .clk(clk), .reset(reset), .move_tick(move_tick),
        .head_position(head_position), .headplusbody(headplusbody),
        .food_position(food_position), .food_valid(food_valid),
        .length_up(length_up), .score(score),
        .board_full(board_full), .game_won(game_won)
    );

    snake_food_gen #(.MAX_SCORE(2)) dut2 (
        .clk(clk), .reset(reset), .move_tick(move_tick),
        .head_position(head_position), .headplusbody(headplusbody),
        .food_position(food_position2), .food_valid(food_valid2),
        .length_up(length_up2), .score(score2),
        .board_full(board_full2), .game_won(game_won2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic eat();
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
    endtask

    // Wait (bounded) for food on dut (sel=0) or dut2 (sel=1); returns cycles waited.
    task automatic wait_food(input int sel, input int max, output int cnt);
        cnt = 0;
        while (((sel == 0) ? food_valid : food_valid2) == 1'b0 && cnt < max) begin
            step();
            cnt++;
        end
    endtask

    function automatic logic onehot_ok(input logic [63:0] v);
        return (v != 64'h0) && ((v & (v - 64'h1)) == 64'h0);
    endfunction

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b0;
        move_tick     = 1'b0;
        head_position = '0;
        headplusbody  = '0;
        headplusbody[3] = 8'b0011_1110;
        #2;
        check("rst_food",  64'(food_position), 64'h0);
        check("rst_valid", 64'(food_valid), 64'h0);
        check("rst_len",   64'(length_up), 64'h0);
        check("rst_score", 64'(score), 64'h0);
        check("rst_full",  64'(board_full), 64'h0);
        check("rst_won",   64'(game_won), 64'h0);
        step();
        step();
        reset = 1'b1;

        // First probe at seed index 37 = [4][5], which is free.
        step();
        check("p1_food",  64'(food_position), 64'h1 << 37);
        check("p1_valid", 64'(food_valid), 64'h1);
        check("p1_score", 64'(score), 64'h0);

        // Head on food without move_tick must not eat.
        head_position[4][5] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_len", 64'(length_up), 64'h0);
        end
        check("hold_score", 64'(score), 64'h0);
        check("hold_food",  64'(food_position), 64'h1 << 37);

        // Eat with tick.
        eat();
        check("eat1_len",   64'(length_up), 64'h1);
        check("eat1_score", 64'(score), 64'h1);
        check("eat1_valid", 64'(food_valid), 64'h0);
        step();
        check("eat1_len_fall", 64'(length_up), 64'h0);
        wait_food(0, 64, n);
        check("eat1_refood", 64'(food_valid), 64'h1);
        check("eat1_free",   64'(food_position) & 64'(headplusbody), 64'h0);
        check("eat1_onehot", 64'(onehot_ok(64'(food_position))), 64'h1);

        // Only [0][0] free: search must wrap to index 0.
        headplusbody = '1;
        headplusbody[0][0] = 1'b0;
        head_position = food_position;
        eat();
        check("eat2_len",   64'(length_up), 64'h1);
        check("eat2_score", 64'(score), 64'h2);
        wait_food(0, 64, n);
        check("wrap_valid", 64'(food_valid), 64'h1);
        check("wrap_food",  64'(food_position), 64'h1);

        // Fully occupied: board_full on exactly the 64th search edge.
        headplusbody = '1;
        head_position = food_position;
        eat();
        check("eat3_len",   64'(length_up), 64'h1);
        check("eat3_score", 64'(score), 64'h3);
        for (int i = 0; i < 63; i++) step();
        check("full_early", 64'(board_full), 64'h0);
        step();
        check("full_set",   64'(board_full), 64'h1);
        check("full_valid", 64'(food_valid), 64'h0);
        headplusbody = '0;
        for (int i = 0; i < 4; i++) step();
        check("full_hold",  64'(board_full), 64'h1);
        check("full_novalid", 64'(food_valid), 64'h0);

        // Win with MAX_SCORE = 2 on dut2.
        reset = 1'b0;
        head_position = '0;
        headplusbody = '0;
        headplusbody[3] = 8'b0011_1110;
        step();
        reset = 1'b1;
        step();
        check("w_food", 64'(food_position2), 64'h1 << 37);
        head_position = food_position2;
        eat();
        check("w1_len",   64'(length_up2), 64'h1);
        check("w1_score", 64'(score2), 64'h1);
        check("w1_won",   64'(game_won2), 64'h0);
        step();
        wait_food(1, 64, n);
        check("w1_refood", 64'(food_valid2), 64'h1);
        head_position = food_position2;
        eat();
        check("w2_len",   64'(length_up2), 64'h1);
        check("w2_score", 64'(score2), 64'h2);
        check("w2_won",   64'(game_won2), 64'h1);
        check("w2_valid", 64'(food_valid2), 64'h0);
        head_position = '1;
        move_tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("done_len", 64'(length_up2), 64'h0);
        end
        move_tick = 1'b0;
        check("done_score", 64'(score2), 64'h2);
        check("done_won",   64'(game_won2), 64'h1);
        check("done_valid", 64'(food_valid2), 64'h0);

        // Async reset clears outputs before the next edge.
        reset = 1'b0;
        #1;
        check("arst_score", 64'(score2), 64'h0);
        check("arst_won",   64'(game_won2), 64'h0);
        check("arst_food",  64'(food_position2), 64'h0);
        check("arst_valid", 64'(food_valid2), 64'h0);
        check("arst_full",  64'(board_full), 64'h0);
        check("arst_len",   64'(length_up2), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/snake_food_gen.md
Name: snake_food_gen

Overview:
- Downstream stage of the snake mover. Consumes the head one-hot map and the head+body occupancy map on the 8x8 LED grid.
- Places food on a pseudo-random free cell and detects when the head lands on it.
- Pulses `length_up` back to the mover and keeps the score.
- Sits between the snake mover and the LED matrix driver; `food_position` is OR-ed into the displayed frame.

Parameters:
- LFSR_SEED, 8'hA5, nonzero LFSR reset value. 0 is replaced by 8'h01.
- MAX_SCORE, 60, score at which the game is won and food placement stops.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- move_tick  in  1  one-cycle pulse, high on the cycle the snake advances
- head_position  in  [7:0][7:0]  one-hot head map, bit [y][x]
- headplusbody  in  [7:0][7:0]  occupancy map (head | body), bit [y][x]
- food_position  out  [7:0][7:0]  one-hot food map; all zero when no food
- food_valid  out  1  food currently placed
- length_up  out  1  one-cycle pulse, snake ate food
- score  out  8  foods eaten, binary, saturates at MAX_SCORE
- board_full  out  1  no free cell found; sticky until reset
- game_won  out  1  score == MAX_SCORE; sticky until reset

Behaviour:
- Cell index: idx[5:0] = {y[2:0], x[2:0]}. The cell is free when headplusbody[y][x] == 0.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Shifts on every clk outside reset and is never zero.
- Reset (reset==0, async) forces:
  - food_position=0, food_valid=0, length_up=0, score=0, board_full=0, game_won=0
  - lfsr=LFSR_SEED, probe_idx=LFSR_SEED[5:0], probe_cnt=0, state=SEARCH
- State SEARCH (one probe per clk):
  - If cell probe_idx is free: food_position <= onehot(probe_idx), food_valid <= 1, go to ARMED.
  - Otherwise: probe_idx <= probe_idx+1 (mod 64, wraps 63->0), probe_cnt++.
  - If probe_cnt reaches 64 with every probe occupied: board_full <= 1, go to FULL.
  - Worst case is 64 cycles.
  - move_tick is ignored in SEARCH; length_up stays 0.
- State ARMED:
  - On a clk where move_tick==1 and (head_position & food_position) != 0, the eat event fires on that edge:
    - length_up <= 1 for exactly one cycle
    - score <= score+1
    - food_position <= 0, food_valid <= 0
    - probe_idx <= lfsr[5:0], probe_cnt <= 0
    - Next state: SEARCH, or DONE with game_won <= 1 if score+1 == MAX_SCORE.
  - Head overlapping food without move_tick does not eat.
  - move_tick with no overlap: no change.
- State FULL: food_valid=0; stays until reset.
- State DONE: food_valid=0, game_won=1; score held at MAX_SCORE; stays until reset.
- Latency:
  - Eat edge to length_up high: 1 cycle.
  - length_up falls on the following edge.
  - Eat to new food: 1 to 64 SEARCH cycles after length_up.
- Occupancy is sampled live each SEARCH cycle. Changes mid-search are honoured on the next probe.
- Reset asserted mid-SEARCH or mid-length_up pulse clears all outputs immediately, without waiting for clk.
- length_up is never high on two consecutive cycles.

Test Plan:
- Release reset; headplusbody = row 3 bits 1..5 only.
  -> After first clk edge: food_position[4][5]=1 (idx 37 from seed A5), food_valid=1, score=0.
- Food at [4][5]; drive head_position[4][5]=1 with move_tick=1 for one cycle.
  -> Next cycle: length_up=1, score=1, food_valid=0.
  -> Cycle after: length_up=0.
  -> Within 64 cycles: food_valid=1 on a cell with headplusbody bit 0.
- head_position[4][5]=1 with move_tick=0 for 5 cycles.
  -> length_up stays 0, score stays 0, food stays at [4][5].
- headplusbody all ones except [0][0]; force an eat.
  -> New food at [0][0] within 64 SEARCH cycles; wrap from idx 63 to 0 exercised.
- headplusbody all ones; force an eat.
  -> Exactly 64 SEARCH cycles later: board_full=1, food_valid=0, held until reset.
- Set MAX_SCORE=2; perform two eats.
  -> score=2, game_won=1, food_valid=0.
  -> Further move_tick/overlap produces no length_up.
  -> Pull reset low mid-run: all outputs 0 before the next clk edge.
